irq_controller: RTL



---
 rtl/irq_controller.sv | 131 +++++++++++++
 1 files changed

// File: rtl/irq_controller.sv
// Interrupt controller: masks N_IRQ level requests with mie, arbitrates, presents int_o/mcause_o, acks on mret.
// Latency: int_o rises 1 cycle after a source becomes eligible; irq_ack_o pulses 1 cycle after int_rst_i in ACTIVE.
// Backpressure: a serviced source stays blocked until its level drops; no preemption while a handler is active.
// Ports: clk_i/rstn (async active-low), irq_req_i[N_IRQ], mie_i[32], int_rst_i -> int_o, mcause_o[32], irq_ack_o[N_IRQ].
// Build option: define IRQ_ROUND_ROBIN_EN for rotating priority (search starts after the last serviced id);
// otherwise fixed priority with the lowest index winning.
module irq_controller #(
    parameter int N_IRQ = 16
) (
    input  logic             clk_i,
    input  logic             rstn,
    input  logic [N_IRQ-1:0] irq_req_i,
    input  logic [31:0]      mie_i,
    input  logic             int_rst_i,
    output logic             int_o,
    output logic [31:0]      mcause_o,
    output logic [N_IRQ-1:0] irq_ack_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [N_IRQ-1:0]   blocked;
    logic [N_IRQ-1:0]   eligible;
    logic [N_IRQ-1:0]   ack_vec;
    logic [31:0]        elig_ext;
    logic [4:0]         id;
    logic [4:0]         winner;
    logic [4:0]         cand;
    logic               found;
    logic               unused_mie;

    // Mask bits above N_IRQ have no source behind them.
    assign unused_mie = ^mie_i;

    assign eligible = irq_req_i & mie_i[N_IRQ-1:0] & ~blocked;
    // Widened so the arbiter can index with a full 5-bit id for any N_IRQ.
    assign elig_ext = 32'(eligible);

`ifdef IRQ_ROUND_ROBIN_EN
    logic [4:0] last_id;
    logic [5:0] base;
    logic [5:0] sum;

    always_comb begin
        if (last_id == 5'(N_IRQ - 1)) begin
            base = 6'd0;
        end else begin
            base = {1'b0, last_id} + 6'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            last_id <= 5'(N_IRQ - 1);
        end else if (state == ACK) begin
            last_id <= id;
        end
    end
`endif

    // First eligible source in search order wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
`ifdef IRQ_ROUND_ROBIN_EN
        sum    = '0;
`endif
        for (int i = 0; i < N_IRQ; i++) begin
`ifdef IRQ_ROUND_ROBIN_EN
            sum = base + 6'(i);
            if (sum >= 6'(N_IRQ)) begin
                sum = sum - 6'(N_IRQ);
            end
            cand = sum[4:0];
`else
            cand = 5'(i);
`endif
            if (!found && elig_ext[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = ACTIVE;
            // int_rst_i is only honoured once the FSM is already in ACTIVE.
            ACTIVE:  if (int_rst_i) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            id       <= '0;
            mcause_o <= '0;
            blocked  <= '0;
        end else begin
            state   <= state_nxt;
            // Set on ack, but a low level always clears: a source that already
            // dropped during ACK may re-raise immediately.
            blocked <= (blocked | ack_vec) & irq_req_i;
            if (state == IDLE && found) begin
                id       <= winner;
                mcause_o <= {1'b1, 26'b0, winner};
            end
        end
    end

    always_comb begin
        ack_vec = '0;
        for (int k = 0; k < N_IRQ; k++) begin
            ack_vec[k] = (state == ACK) && (id == 5'(k));
        end
    end

    assign irq_ack_o = ack_vec;
    assign int_o     = (state == ACTIVE);

endmodule
